vcr_ip_chan_rcv: RTL and testbench
==================================

// Module: vcr_ip_chan_rcv
// PURPOSE
// Input-port channel receiver: the downstream end of the credit-flow-controlled router link.
// Decodes incoming channel flits into per-VC static-partition FIFOs and exposes head-of-queue state to allocation.
// Returns one credit per popped flit on flow_ctrl_out to the upstream output port controller.
// PARAMETERS
// buffer_size           32  total flits per port; per-VC depth D = buffer_size/num_vcs (power of 2, >=2)
// num_message_classes   2   message classes
// num_resource_classes  2   resource classes
// num_vcs_per_class     1   VCs per packet class; num_vcs = product of the three; vc_idx_width = clogb(num_vcs)
// packet_format         `PACKET_FORMAT_HEAD_TAIL  HEAD_TAIL or TAIL_ONLY; others unsupported
// enable_link_pm        1   channel carries 1 link-ctrl MSB
// flit_data_width       64  payload bits
// error_capture_mode    `ERROR_CAPTURE_MODE_NO_HOLD  per vcr_constants
// PORTS
// clk            in   1    clock
// reset          in   1    synchronous, active-high
// channel_in     in   link_ctrl+flit_ctrl+flit_data_width  {link, valid, vc_idx, [head], tail, data}
// pop_valid      in   1    pop one flit this cycle
// pop_ivc        in   num_vcs  one-hot VC to pop
// empty_ivc      out  num_vcs  per-VC FIFO empty
// head_ivc       out  num_vcs  head-of-queue flit is a head flit
// tail_ivc       out  num_vcs  head-of-queue flit is a tail flit
// flit_data_out  out  flit_data_width  head-of-queue data of VC in pop_ivc (combinational)
// flow_ctrl_out  out  1+vc_idx_width  {credit_valid, credit_vc}
// error          out  1    OR of captured errors
// BEHAVIOUR
// - Reset: empty_ivc all 1, head/tail_ivc 0, flow_ctrl_out 0, error 0, pointers/occupancy 0, in-packet flags 0.
// - Input stage: channel_in registered every cycle; with enable_link_pm, register loads only when link bit=1, else holds with valid forced 0.
// - Latency: flit on channel_in in cycle t -> staged t+1 -> written at end of t+1 -> empty_ivc low in t+2.
// - FIFO per VC: rd/wr pointers log2(D) bits wrap modulo D; occupancy 0..D (log2(D)+1 bits). Storage: flops, data+head+tail.
// - Push with occupancy==D: flit dropped, occupancy stays D, overflow error for that VC.
// - Pop with empty VC: no state change, underflow error; no push-to-pop bypass, even same cycle.
// - Simultaneous push+pop same VC: both happen, occupancy unchanged (valid at D: pop frees slot first).
// - Credit: pop accepted in cycle t -> flow_ctrl_out = {1, binary(pop VC)} in t+1 only; else {0, 0}. Max 1 credit/cycle.
// - pop_ivc not one-hot while pop_valid: no pop, no credit, multisel error.
// - HEAD_TAIL: per-VC in_pkt flag set on head&~tail, cleared on tail; head while in_pkt or non-head while ~in_pkt -> framing error (flit still stored).
// - TAIL_ONLY: head bit inferred = ~in_pkt for that VC; stored alongside data.
// - Errors: {multisel, overflow[num_vcs], underflow[num_vcs], framing[num_vcs]} into c_err_rpt; error registered, 1 cycle late.
// - Reset mid-packet: all FIFOs flushed, in_pkt cleared, no credit issued for discarded flits (upstream reset together).
// STRUCTURE
// - Constants in vcr_constants/rtr_constants (packet format, error capture); clogb from c_functions.
// - Sub-module vcr_ivc_fifo (one per VC via generate): push/pop, pointers, occupancy, full/empty, overflow/underflow flags.
// - Top: input staging, VC decode, framing/in_pkt tracking, output mux, credit register, error aggregation.
// TESTING
// - Reset: assert 2 cycles -> empty_ivc=4'b1111, flow_ctrl_out=0, error=0.
// - Single flit vc=0 head+tail, data 'hA5 at t -> empty_ivc[0]=0 at t+2; pop at t+2 -> data 'hA5, flow_ctrl_out={1,2'd0} at t+3, empty at t+3.
// - Fill VC1 with D=8 flits, send 9th -> occupancy 8, error=1 two cycles later; pop 8 -> data in order, 8 credits vc=1.
// - Stream 3*D flits to VC2 with concurrent pops every cycle once nonempty -> all data in order across pointer wrap, no error.
// - TAIL_ONLY: 3-flit pkt then 1-flit pkt on VC3 -> head_ivc at queue top sequence 1,0,0,1.
// - Two heads back-to-back on VC0 in HEAD_TAIL -> framing error; reset mid-packet -> empty all, no credits.

Source files
------------

// File: rtl/vcr_ip_chan_rcv_pkg.sv
// rtl/vcr_ip_chan_rcv_pkg.sv - shared constants and helpers for the input-port channel receiver
package vcr_ip_chan_rcv_pkg;

    localparam int PACKET_FORMAT_TAIL_ONLY = 0;
    localparam int PACKET_FORMAT_HEAD_TAIL = 1;

    localparam int ERROR_CAPTURE_MODE_NONE    = 0;
    localparam int ERROR_CAPTURE_MODE_NO_HOLD = 1;
    localparam int ERROR_CAPTURE_MODE_HOLD    = 2;

    // Ceiling log2; clogb(1) is 0.
    function automatic int clogb(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vcr_ivc_fifo.sv
// rtl/vcr_ivc_fifo.sv - one statically partitioned per-VC flit FIFO
module vcr_ivc_fifo
    import vcr_ip_chan_rcv_pkg::*;
#(
    parameter int depth      = 8,
    parameter int data_width = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  push_head,
    input  logic                  push_tail,
    input  logic                  pop,
    output logic [data_width-1:0] head_data,
    output logic                  head_head,
    output logic                  head_tail,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int ptr_width = clogb(depth);

    logic [ptr_width-1:0] rd_ptr;
    logic [ptr_width-1:0] wr_ptr;
    logic [ptr_width:0]   occupancy;
    logic [data_width+1:0] mem [depth];
    logic full;
    logic pop_ok;
    logic push_ok;

    assign empty     = (occupancy == '0);
    assign full      = (occupancy == (ptr_width+1)'(depth));
    // No bypass: a pop only sees what was stored before this cycle, but a
    // concurrent pop on a full queue frees the slot the push needs.
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign overflow  = push && !push_ok;
    assign underflow = pop && empty;

    assign head_data = mem[rd_ptr][data_width-1:0];
    assign head_tail = mem[rd_ptr][data_width];
    assign head_head = mem[rd_ptr][data_width+1];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {push_head, push_tail, push_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ptr_width'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ptr_width'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   occupancy <= occupancy + (ptr_width+1)'(1);
                2'b01:   occupancy <= occupancy - (ptr_width+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/vcr_ip_chan_rcv.sv
// rtl/vcr_ip_chan_rcv.sv - router input-port channel receiver with per-VC FIFOs and credit return
module vcr_ip_chan_rcv
    import vcr_ip_chan_rcv_pkg::*;
#(
    parameter int buffer_size          = 32,
    parameter int num_message_classes  = 2,
    parameter int num_resource_classes = 2,
    parameter int num_vcs_per_class    = 1,
    parameter int packet_format        = PACKET_FORMAT_HEAD_TAIL,
    parameter int enable_link_pm       = 1,
    parameter int flit_data_width      = 64,
    parameter int error_capture_mode   = ERROR_CAPTURE_MODE_NO_HOLD,
    localparam int num_vcs         = num_message_classes * num_resource_classes * num_vcs_per_class,
    localparam int vc_idx_width    = clogb(num_vcs),
    localparam int link_ctrl_width = (enable_link_pm != 0) ? 1 : 0,
    localparam int flit_ctrl_width = 1 + vc_idx_width + ((packet_format == PACKET_FORMAT_HEAD_TAIL) ? 2 : 1),
    localparam int channel_width   = link_ctrl_width + flit_ctrl_width + flit_data_width
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [channel_width-1:0]   channel_in,
    input  logic                       pop_valid,
    input  logic [num_vcs-1:0]         pop_ivc,
    output logic [num_vcs-1:0]         empty_ivc,
    output logic [num_vcs-1:0]         head_ivc,
    output logic [num_vcs-1:0]         tail_ivc,
    output logic [flit_data_width-1:0] flit_data_out,
    output logic [vc_idx_width:0]      flow_ctrl_out,
    output logic                       error
);

    localparam int depth     = buffer_size / num_vcs;
    localparam int tail_pos  = flit_data_width;
    localparam int vc_pos    = (packet_format == PACKET_FORMAT_HEAD_TAIL) ? tail_pos + 2 : tail_pos + 1;
    localparam int valid_pos = vc_pos + vc_idx_width;

    logic link_up;
    logic in_head;

    if (enable_link_pm != 0) begin : g_link
        assign link_up = channel_in[valid_pos+1];
    end else begin : g_no_link
        assign link_up = 1'b1;
    end

    if (packet_format == PACKET_FORMAT_HEAD_TAIL) begin : g_head_bit
        assign in_head = channel_in[tail_pos+1];
    end else begin : g_no_head_bit
        assign in_head = 1'b0;
    end

    logic                       stg_valid;
    logic                       stg_head;
    logic                       stg_tail;
    logic [vc_idx_width-1:0]    stg_vc;
    logic [flit_data_width-1:0] stg_data;

    // While the link is powered down the staged fields hold and only valid drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= 1'b0;
            stg_head  <= 1'b0;
            stg_tail  <= 1'b0;
            stg_vc    <= '0;
            stg_data  <= '0;
        end else if (link_up) begin
            stg_valid <= channel_in[valid_pos];
            stg_head  <= in_head;
            stg_tail  <= channel_in[tail_pos];
            stg_vc    <= channel_in[vc_pos +: vc_idx_width];
            stg_data  <= channel_in[flit_data_width-1:0];
        end else begin
            stg_valid <= 1'b0;
        end
    end

    logic [num_vcs-1:0] in_pkt;
    logic [num_vcs-1:0] push_ivc;
    logic [num_vcs-1:0] framing_ivc;
    logic               flit_head;

    assign flit_head = (packet_format == PACKET_FORMAT_HEAD_TAIL) ? stg_head : !in_pkt[stg_vc];

    // A head must open a packet and a non-head must continue one; both cases
    // reduce to the head bit disagreeing with the current in-packet state.
    always_comb begin
        push_ivc    = '0;
        framing_ivc = '0;
        for (int i = 0; i < num_vcs; i++) begin
            push_ivc[i]    = stg_valid && (stg_vc == vc_idx_width'(i));
            framing_ivc[i] = push_ivc[i] && (packet_format == PACKET_FORMAT_HEAD_TAIL)
                             && (stg_head == in_pkt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_pkt <= '0;
        end else if (stg_valid) begin
            if (stg_tail) begin
                in_pkt[stg_vc] <= 1'b0;
            end else if (flit_head) begin
                in_pkt[stg_vc] <= 1'b1;
            end
        end
    end

    logic                       pop_onehot;
    logic                       multisel;
    logic                       pop_accept;
    logic [num_vcs-1:0]         pop_req;
    logic [num_vcs-1:0]         overflow_ivc;
    logic [num_vcs-1:0]         underflow_ivc;
    logic [num_vcs-1:0]         fifo_head;
    logic [num_vcs-1:0]         fifo_tail;
    logic [vc_idx_width-1:0]    pop_vc;
    logic [flit_data_width-1:0] fifo_data [num_vcs];

    assign pop_onehot = $onehot(pop_ivc);
    assign pop_req    = (pop_valid && pop_onehot) ? pop_ivc : '0;
    assign multisel   = pop_valid && !pop_onehot;
    assign pop_accept = |(pop_req & ~empty_ivc);

    for (genvar i = 0; i < num_vcs; i++) begin : g_ivc
        vcr_ivc_fifo #(
            .depth      (depth),
            .data_width (flit_data_width)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .push       (push_ivc[i]),
            .push_data  (stg_data),
            .push_head  (flit_head),
            .push_tail  (stg_tail),
            .pop        (pop_req[i]),
            .head_data  (fifo_data[i]),
            .head_head  (fifo_head[i]),
            .head_tail  (fifo_tail[i]),
            .empty      (empty_ivc[i]),
            .overflow   (overflow_ivc[i]),
            .underflow  (underflow_ivc[i])
        );
    end

    assign head_ivc = fifo_head & ~empty_ivc;
    assign tail_ivc = fifo_tail & ~empty_ivc;

    always_comb begin
        flit_data_out = '0;
        pop_vc        = '0;
        for (int i = 0; i < num_vcs; i++) begin
            if (pop_ivc[i]) begin
                flit_data_out = flit_data_out | fifo_data[i];
                pop_vc        = vc_idx_width'(i);
            end
        end
    end

    logic [3*num_vcs:0] err_vec;
    logic               err_any;

    assign err_vec = {multisel, overflow_ivc, underflow_ivc, framing_ivc};
    assign err_any = |err_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            flow_ctrl_out <= '0;
            error         <= 1'b0;
        end else begin
            flow_ctrl_out <= pop_accept ? {1'b1, pop_vc} : '0;
            case (error_capture_mode)
                ERROR_CAPTURE_MODE_NONE: error <= 1'b0;
                ERROR_CAPTURE_MODE_HOLD: error <= error | err_any;
                default:                 error <= err_any;
            endcase
        end
    end

endmodule

// File: tb/tb_vcr_ip_chan_rcv.sv
// tb/tb_vcr_ip_chan_rcv.sv - self-checking bench for vcr_ip_chan_rcv
module tb_vcr_ip_chan_rcv;
    import vcr_ip_chan_rcv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [69:0] ch1;
    logic [68:0] ch2;
    logic        pop_valid, pop_valid2;
    logic [3:0]  pop_ivc, pop_ivc2;
    logic [3:0]  empty_ivc, head_ivc, tail_ivc, empty2, head2, tail2;
    logic [63:0] dout, dout2;
    logic [2:0]  fc, fc2;
    logic        error1, error2;

    always #5 clk = ~clk;

    vcr_ip_chan_rcv dut (
        .clk(clk), .reset(reset), .channel_in(ch1), .pop_valid(pop_valid), .pop_ivc(pop_ivc),
        .empty_ivc(empty_ivc), .head_ivc(head_ivc), .tail_ivc(tail_ivc),
        .flit_data_out(dout), .flow_ctrl_out(fc), .error(error1)
    );

    vcr_ip_chan_rcv #(.packet_format(PACKET_FORMAT_TAIL_ONLY)) dut_to (
        .clk(clk), .reset(reset), .channel_in(ch2), .pop_valid(pop_valid2), .pop_ivc(pop_ivc2),
        .empty_ivc(empty2), .head_ivc(head2), .tail_ivc(tail2),
        .flit_data_out(dout2), .flow_ctrl_out(fc2), .error(error2)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        h;
        logic        t;
    } ent_t;

    ent_t        q [4][$];
    logic        m_stg_v, m_stg_h, m_stg_t;
    logic [1:0]  m_stg_vc;
    logic [63:0] m_stg_d;
    logic [3:0]  m_in_pkt;
    logic [2:0]  m_fc;
    logic        m_err;
    bit          checking = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: queues per VC, one staging slot for the registered input, pops before pushes.
    task automatic model_edge();
        logic       e;
        logic [2:0] fc_n;
        int         v;
        if (reset) begin
            for (int i = 0; i < 4; i++) q[i].delete();
            m_stg_v = 0; m_in_pkt = '0; m_fc = '0; m_err = 0;
        end else begin
            e = 0; fc_n = '0;
            if (pop_valid) begin
                if ($countones(pop_ivc) != 1) e = 1;
                else begin
                    v = 0;
                    for (int i = 0; i < 4; i++) if (pop_ivc[i]) v = i;
                    if (q[v].size() == 0) e = 1;
                    else begin
                        void'(q[v].pop_front());
                        fc_n = {1'b1, 2'(v)};
                    end
                end
            end
            if (m_stg_v) begin
                v = int'(m_stg_vc);
                if ((m_stg_h && m_in_pkt[v]) || (!m_stg_h && !m_in_pkt[v])) e = 1;
                if (m_stg_t) m_in_pkt[v] = 0;
                else if (m_stg_h) m_in_pkt[v] = 1;
                if (q[v].size() < 8) q[v].push_back('{d: m_stg_d, h: m_stg_h, t: m_stg_t});
                else e = 1;
            end
            m_fc = fc_n; m_err = e;
            if (ch1[69]) begin
                m_stg_v = ch1[68]; m_stg_vc = ch1[67:66]; m_stg_h = ch1[65];
                m_stg_t = ch1[64]; m_stg_d = ch1[63:0];
            end else m_stg_v = 0;
        end
    endtask

    task automatic check_model();
        logic [3:0] ee, eh, et;
        int v;
        for (int i = 0; i < 4; i++) begin
            ee[i] = (q[i].size() == 0); eh[i] = 0; et[i] = 0;
            if (q[i].size() > 0) begin eh[i] = q[i][0].h; et[i] = q[i][0].t; end
        end
        chk("m_empty", empty_ivc, ee);
        chk("m_head", head_ivc, eh);
        chk("m_tail", tail_ivc, et);
        chk("m_credit", fc, m_fc);
        chk("m_error", error1, m_err);
        if ($countones(pop_ivc) == 1) begin
            v = 0;
            for (int i = 0; i < 4; i++) if (pop_ivc[i]) v = i;
            if (q[v].size() > 0) chk("m_data", dout, q[v][0].d);
        end
    endtask

    task automatic tick();
        if (checking) begin
            @(negedge clk);
            check_model();
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic put(input logic [1:0] vc, input logic h, input logic t, input logic [63:0] d);
        ch1 = {1'b1, 1'b1, vc, h, t, d};
    endtask

    initial begin : main
        logic [63:0] d;
        logic [63:0] sq[$];
        logic [3:0]  hseq, tseq;
        int          ncred, sent, popped;
        logic        errseen;

        reset = 1; ch1 = '0; ch2 = '0;
        pop_valid = 0; pop_ivc = '0; pop_valid2 = 0; pop_ivc2 = '0;
        tick(); tick();
        checking = 1;
        reset = 0;
        chk("rst_empty", empty_ivc, 4'b1111);
        chk("rst_credit", fc, 3'b000);
        chk("rst_error", error1, 1'b0);
        chk("rst_head", head_ivc, 4'b0000);

        // single flit, latency and credit
        put(2'd0, 1, 1, 64'hA5); tick();
        ch1 = '0; tick();
        chk("single_empty_t2", empty_ivc[0], 1'b0);
        pop_valid = 1; pop_ivc = 4'b0001; #1;
        chk("single_data", dout, 64'hA5);
        tick();
        pop_valid = 0; pop_ivc = '0;
        chk("single_credit", fc, 3'b100);
        chk("single_empty_t3", empty_ivc[0], 1'b1);
        tick();
        chk("single_credit_once", fc, 3'b000);

        // overflow on VC1
        for (int i = 0; i < 9; i++) begin put(2'd1, 1, 1, 64'h1000 + 64'(i)); tick(); end
        ch1 = '0; tick();
        chk("ovf_error", error1, 1'b1);
        chk("ovf_nonempty", empty_ivc[1], 1'b0);
        ncred = 0;
        pop_valid = 1; pop_ivc = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("ovf_data", dout, 64'h1000 + 64'(i));
            tick();
            if (fc === 3'b101) ncred++;
        end
        pop_valid = 0; pop_ivc = '0;
        chk("ovf_credits", 64'(ncred), 64'd8);
        chk("ovf_drained", empty_ivc[1], 1'b1);
        tick();

        // streaming through pointer wrap on VC2
        sent = 0; popped = 0; errseen = 0;
        for (int c = 0; c < 60 && popped < 24; c++) begin
            if (sent < 24) begin
                d = {$urandom(), $urandom()};
                sq.push_back(d); put(2'd2, 1, 1, d); sent++;
            end else ch1 = '0;
            pop_valid = (q[2].size() > 0);
            pop_ivc = pop_valid ? 4'b0100 : 4'b0000;
            #1;
            if (pop_valid) begin chk("stream_data", dout, sq.pop_front()); popped++; end
            errseen = errseen | error1;
            tick();
        end
        pop_valid = 0; pop_ivc = '0; ch1 = '0;
        errseen = errseen | error1;
        chk("stream_count", 64'(popped), 64'd24);
        chk("stream_no_error", errseen, 1'b0);
        tick(); tick();

        // TAIL_ONLY head inference on VC3 of the second instance
        ch2 = {1'b1, 1'b1, 2'd3, 1'b0, 64'h31}; tick();
        ch2 = {1'b1, 1'b1, 2'd3, 1'b0, 64'h32}; tick();
        ch2 = {1'b1, 1'b1, 2'd3, 1'b1, 64'h33}; tick();
        ch2 = {1'b1, 1'b1, 2'd3, 1'b1, 64'h34}; tick();
        ch2 = '0; tick();
        hseq = '0; tseq = '0;
        for (int i = 0; i < 4; i++) begin
            pop_valid2 = 1; pop_ivc2 = 4'b1000; #1;
            hseq = {hseq[2:0], head2[3]};
            tseq = {tseq[2:0], tail2[3]};
            chk("to_data", dout2, 64'h31 + 64'(i));
            tick();
        end
        pop_valid2 = 0; pop_ivc2 = '0;
        chk("to_head_seq", hseq, 4'b1001);
        chk("to_tail_seq", tseq, 4'b0011);
        chk("to_drained", empty2[3], 1'b1);

        // framing: two heads back to back on VC0, then reset mid-packet
        put(2'd0, 1, 0, 64'hB1); tick();
        put(2'd0, 1, 0, 64'hB2); tick();
        ch1 = '0; tick();
        chk("framing_error", error1, 1'b1);
        reset = 1; tick(); tick();
        reset = 0;
        chk("rst_mid_empty", empty_ivc, 4'b1111);
        chk("rst_mid_credit", fc, 3'b000);
        tick();
        chk("rst_mid_no_credit", fc, 3'b000);
        put(2'd0, 1, 0, 64'hC1); tick();
        ch1 = '0; tick();
        chk("post_reset_no_framing", error1, 1'b0);
        put(2'd0, 0, 1, 64'hC2); tick();
        ch1 = '0; tick();

        // randomized traffic: a filling phase then a draining phase
        for (int n = 0; n < 400; n++) begin
            ch1 = {($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, 1'($urandom()), 2'($urandom()),
                   1'($urandom()), 1'($urandom()), $urandom(), $urandom()};
            pop_valid = (n < 200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) pop_ivc = 4'($urandom());
            else pop_ivc = 4'b0001 << $urandom_range(0, 3);
            tick();
        end
        ch1 = '0; pop_valid = 0; pop_ivc = '0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
